// File: rtl/n_bit_serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// With SERIAL_SUB_ADD_MODE_EN defined, an op bit selects add (1) or subtract (0).
interface n_bit_serial_subtractor_if #(
    parameter int unsigned n = 4
);
    logic         start;
    logic [n-1:0] a_in;
    logic [n-1:0] b_in;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic         op;
`endif
    logic         busy;
    logic         done;
    logic [n-1:0] diff;
    logic         borrow;
    logic         serial_out;

    modport master (
        output start, a_in, b_in,
`ifdef SERIAL_SUB_ADD_MODE_EN
        output op,
`endif
        input  busy, done, diff, borrow, serial_out
    );

    modport slave (
        input  start, a_in, b_in,
`ifdef SERIAL_SUB_ADD_MODE_EN
        input  op,
`endif
        output busy, done, diff, borrow, serial_out
    );
endinterface

// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell and one borrow flop.
// Optional add mode is enabled with SERIAL_SUB_ADD_MODE_EN.
module n_bit_serial_subtractor #(
    parameter int unsigned n = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    n_bit_serial_subtractor_if.slave  bus
);
    localparam int unsigned CW = (n > 2) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [n-1:0]  a_reg;
    logic [n-1:0]  b_reg;
    logic [n-1:0]  diff_q;
    logic [CW-1:0] cnt;
    logic          bw;
    logic          borrow_q;
    logic          done_q;
    logic          busy_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic          op_q;
`endif

    logic d_c;
    logic bw_next_c;
    logic accept_c;

    // Single cell: difference (or sum) bit and next borrow (or carry).
    always_comb begin
        d_c       = a_reg[0] ^ b_reg[0] ^ bw;
        bw_next_c = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & bw);
`ifdef SERIAL_SUB_ADD_MODE_EN
        if (op_q) begin
            bw_next_c = (a_reg[0] & b_reg[0]) | (a_reg[0] & bw) | (b_reg[0] & bw);
        end
`endif
    end

    // The DONE exit edge also accepts a new start so back-to-back ops take n+1 cycles.
    assign accept_c = bus.start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            diff_q   <= '0;
            cnt      <= '0;
            bw       <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            op_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SHIFT;
                        busy_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    a_reg <= {d_c, a_reg[n-1:1]};
                    b_reg <= {b_reg[0], b_reg[n-1:1]};
                    bw    <= bw_next_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q   <= 1'b0;
                    diff_q   <= a_reg;
                    borrow_q <= bw;
                    if (bus.start) begin
                        state <= SHIFT;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase

            // Operand capture; never overlaps the SHIFT-state updates above.
            if (accept_c) begin
                a_reg <= bus.a_in;
                b_reg <= bus.b_in;
                bw    <= 1'b0;
                cnt   <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                op_q  <= bus.op;
`endif
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = (state == DONE) ? a_reg : diff_q;
    assign bus.borrow     = (state == DONE) ? bw : borrow_q;
    assign bus.serial_out = (state == SHIFT) ? d_c : 1'b0;

endmodule
